// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle multiply/divide engine writing a HI/LO pair.
// Signed operands are reduced to magnitudes at start and the sign is fixed up
// in a single correction cycle. This keeps one unsigned datapath for all four ops.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;   // negate product / quotient
  logic                 r_neg_r;   // negate remainder (dividend was negative)
  logic                 r_div0;    // signed divide by zero: LO is forced
  logic [WIDTH-1:0]     r_m;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     r_q;       // multiplier (shifts out) or dividend/quotient
  logic [WIDTH-1:0]     r_acc;     // product high half or partial remainder
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;

  // Operand conditioning at start: MULT and DIV (op[0]=0) are the signed ops.
  logic                 w_signed;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  assign w_signed = ~op[0];
  assign w_a_abs  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_abs  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Multiply step: conditionally add, then shift {acc,q} right by one.
  logic [WIDTH:0]       w_sum;
  assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);

  // Divide step: shift in the next dividend bit, trial subtract, restore on borrow.
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem_next;
  assign w_shift    = {r_acc, r_q[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_m};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_neg;
  assign w_prod     = {r_acc, r_q};
  assign w_prod_neg = -w_prod;

  // Control FSM and datapath registers; all outputs are registered here.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_m      <= '0;
      r_q      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            // start has priority over a coincident MTHI/MTLO write
            r_is_div <= op[1];
            r_m      <= op[1] ? w_b_abs : w_a_abs;
            r_q      <= op[1] ? w_a_abs : w_b_abs;
            r_acc    <= '0;
            r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= w_signed && op[1] && a[WIDTH-1];
            r_div0   <= (op == 2'b10) && (b == '0);
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_acc <= w_rem_next;
            r_q   <= {r_q[WIDTH-2:0], w_qbit};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= r_neg_r ? -r_acc : r_acc;
            r_lo <= r_div0 ? '1 : (r_neg_q ? -r_q : r_q);
          end else begin
            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, hand-written corner sequences and
// random operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'b0, ma};
    ub = {32'b0, mb};
    case (mop)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (mb == 32'h0) return {ma, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (mb == 32'h0) return {ma, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Launch one op at the next edge (N) and wait for done. poke_at>0 pulses
  // start(DIVU)+lo_we that many cycles into the run; hiwe_start drives hi_we
  // together with start. Called and returning at posedge+1.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke_at, input bit hiwe_start,
                        output logic [31:0] rhi, output logic [31:0] rlo);
    logic [31:0] hi_before;
    bit          busy_ok;
    int          k;
    hi_before = hi;
    op = o; a = x; b = y; start = 1'b1;
    if (hiwe_start) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check({name, " busy_after_start"}, 64'(busy), 64'(1));
    check({name, " hi_held_at_start"}, 64'(hi), 64'(hi_before));
    busy_ok = 1'b1;
    k = 1;
    while (k <= 40) begin
      if (k == poke_at) begin
        start = 1'b1; op = 2'b11; a = 32'h55; b = 32'h3;
        lo_we = 1'b1; wdata = 32'h0BAD_0BAD;
      end
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      k++;
    end
    check({name, " latency"}, 64'(k), 64'(33));
    check({name, " busy_during_run"}, 64'(busy_ok), 64'(1));
    check({name, " busy_low_at_done"}, 64'(busy), 64'(0));
    rhi = hi;
    rlo = lo;
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, 64'(done), 64'(0));
  endtask

  vec_t        vecs[10];
  logic [31:0] rh, rl;
  logic [63:0] exp64;
  logic [1:0]  rop;
  logic [31:0] ra, rb;
  bit          saw_done;

  initial begin
    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[6] = '{2'b11, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF};
    vecs[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[8] = '{2'b10, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[9] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, rh, rl);
      check($sformatf("vec%0d hi", i), 64'(rh), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d lo", i), 64'(rl), 64'(vecs[i].exp_lo));
    end

    // MTHI in idle
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1 hi_we = 1'b0;
    check("mthi idle", 64'(hi), 64'(32'hA5A5_A5A5));
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h1357_9BDF;
    @(posedge clk); #1 lo_we = 1'b0; hi_we = 1'b0;
    check("mthi+mtlo hi", 64'(hi), 64'(32'h1357_9BDF));
    check("mthi+mtlo lo", 64'(lo), 64'(32'h1357_9BDF));

    // start + lo_we during busy ignored
    run_op("busy_poke", 2'b01, 32'd3, 32'd5, 10, 1'b0, rh, rl);
    check("busy_poke hi", 64'(rh), 64'(0));
    check("busy_poke lo", 64'(rl), 64'(15));

    // start together with hi_we in idle: write dropped
    hi_we = 1'b1; wdata = 32'h1111_1111;
    @(posedge clk); #1 hi_we = 1'b0;
    run_op("start_hiwe", 2'b01, 32'd3, 32'd5, 0, 1'b1, rh, rl);
    check("start_hiwe hi", 64'(rh), 64'(0));
    check("start_hiwe lo", 64'(rl), 64'(15));

    // Reset mid-operation
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst hi", 64'(hi), 64'(0));
    check("midrst lo", 64'(lo), 64'(0));
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst no_done", 64'(saw_done), 64'(0));
    run_op("after_rst", 2'b01, 32'd2, 32'd3, 0, 1'b0, rh, rl);
    check("after_rst hi", 64'(rh), 64'(0));
    check("after_rst lo", 64'(rl), 64'(6));

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp64 = model(rop, ra, rb);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 0, 1'b0, rh, rl);
      check($sformatf("rnd%0d op%0d a=%h b=%h hilo", i, rop, ra, rb), {rh, rl}, exp64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
